// File: rtl/state_arbiter_pkg.sv
// Shared types and helpers for the state arbiter and related round-robin gears.
package state_arbiter_pkg;

    localparam int DEFAULT_NW = 4;

    typedef logic [$clog2(DEFAULT_NW)-1:0] idx_t;

    // Round-robin successor: the slot after ptr, wrapping back to 0 past nw-1.
    function automatic int rr_next(input int ptr, input int nw);
        return (ptr + 1 >= nw) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/state_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after ptr.
module rr_arbiter #(
    parameter int NW = 4,
    parameter int IW = $clog2(NW)
) (
    input  logic [NW-1:0] req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [NW-1:0] gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    logic [IW-1:0] cand;

    // Walk the ring starting at ptr; the first live request wins and masks the rest.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int k = 0; k < NW; k++) begin
            cand = IW'((int'(ptr) + k) % NW);
            if (en && !gnt_any && req[cand]) begin
                gnt_any   = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/state_arbiter.sv
// Shared state register with round-robin writers and a stall-safe read port.
// Define STATE_ARBITER_FWD_EN to forward the granted write data straight to dout_data.
module state_arbiter
    import state_arbiter_pkg::*;
#(
    parameter int          NW   = 4,
    parameter int          W    = 16,
    parameter logic [W-1:0] INIT = '0,
    parameter int          CW   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NW*W-1:0]        wr_data,
    input  logic [NW-1:0]          wr_valid,
    output logic [NW-1:0]          wr_ready,
    input  logic                   rd_valid,
    output logic                   rd_ready,
    output logic [W-1:0]           dout_data,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic [$clog2(NW)-1:0]  grant_idx,
    output logic [CW-1:0]          upd_cnt
);

    localparam int IW = $clog2(NW);

    logic [W-1:0]  state_reg;
    logic [W-1:0]  sel_data;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] gnt_idx;
    logic          gnt_any;
    logic          stall;
    logic          arb_en;

    // Writes are frozen while a read response is waiting, so dout_data cannot move under it.
    assign stall      = rd_valid && !dout_ready;
    assign arb_en     = !stall && !rst;
    assign rd_ready   = dout_ready;
    assign dout_valid = rd_valid;

    rr_arbiter #(
        .NW (NW),
        .IW (IW)
    ) u_arb (
        .req     (wr_valid),
        .ptr     (rr_ptr),
        .en      (arb_en),
        .gnt     (wr_ready),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign sel_data = wr_data[int'(gnt_idx)*W +: W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= INIT;
            rr_ptr    <= '0;
            upd_cnt   <= '0;
            grant_idx <= '0;
        end else if (gnt_any) begin
            state_reg <= sel_data;
            rr_ptr    <= IW'(rr_next(int'(gnt_idx), NW));
            upd_cnt   <= upd_cnt + CW'(1);
            grant_idx <= gnt_idx;
        end
    end

    always_comb begin
        dout_data = state_reg;
`ifdef STATE_ARBITER_FWD_EN
        if (gnt_any) begin
            dout_data = sel_data;
        end
`endif
    end

endmodule

// File: tb/tb_state_arbiter.sv
// Self-checking bench for state_arbiter: per-cycle reference model plus directed literal checks.
module tb_state_arbiter;

    localparam int NW = 4;
    localparam int W  = 16;
    localparam int CW = 8;
    localparam logic [W-1:0] INIT = 16'h00A5;

    logic            clk = 1'b0;
    logic            rst;
    logic [NW*W-1:0] wr_data;
    logic [NW-1:0]   wr_valid;
    logic [NW-1:0]   wr_ready;
    logic            rd_valid;
    logic            rd_ready;
    logic [W-1:0]    dout_data;
    logic            dout_valid;
    logic            dout_ready;
    logic [1:0]      grant_idx;
    logic [CW-1:0]   upd_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    state_arbiter #(
        .NW   (NW),
        .W    (W),
        .INIT (INIT),
        .CW   (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .dout_data  (dout_data),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .grant_idx  (grant_idx),
        .upd_cnt    (upd_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_cnt++;
        if (actual === expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [NW-1:0] valid, input logic rv, input logic dr);
        @(posedge clk);
        #1;
        wr_valid   = valid;
        rd_valid   = rv;
        dout_ready = dr;
    endtask

    task automatic setData(input int i, input logic [W-1:0] val);
        wr_data[i*W +: W] = val;
    endtask

    // Reference model: register value, ring pointer, counter and last grant as plain integers.
    int m_state, m_ptr, m_cnt, m_gidx;
    bit model_ok = 0;

    always @(negedge clk) begin
        int g;
        int c;
        int exp_dout;
        int exp_ready;
        if (rst) begin
            checkOutput("rst_wr_ready", 32'(wr_ready), 32'd0);
            checkOutput("rst_rd_ready", 32'(rd_ready), 32'(dout_ready));
            m_state  = int'(INIT);
            m_ptr    = 0;
            m_cnt    = 0;
            m_gidx   = 0;
            model_ok = 1;
        end else if (model_ok) begin
            g = -1;
            if (!(rd_valid && !dout_ready)) begin
                for (int k = 0; k < NW; k++) begin
                    c = (m_ptr + k) % NW;
                    if (g < 0 && wr_valid[c]) g = c;
                end
            end
            exp_ready = (g >= 0) ? (1 << g) : 0;
            exp_dout  = m_state;
`ifdef STATE_ARBITER_FWD_EN
            if (g >= 0) exp_dout = int'(wr_data[g*W +: W]);
`endif
            checkOutput("mdl_wr_ready",   32'(wr_ready),   32'(exp_ready));
            checkOutput("mdl_dout_data",  32'(dout_data),  32'(exp_dout));
            checkOutput("mdl_dout_valid", 32'(dout_valid), 32'(rd_valid));
            checkOutput("mdl_rd_ready",   32'(rd_ready),   32'(dout_ready));
            checkOutput("mdl_upd_cnt",    32'(upd_cnt),    32'(m_cnt));
            checkOutput("mdl_grant_idx",  32'(grant_idx),  32'(m_gidx));
            if (g >= 0) begin
                m_state = int'(wr_data[g*W +: W]);
                m_ptr   = (g + 1) % NW;
                m_cnt   = (m_cnt + 1) % (1 << CW);
                m_gidx  = g;
            end
        end
    end

    logic [NW-1:0] rr_gnt  [5];
    logic [W-1:0]  rr_dout [5];

    initial begin
        rr_gnt  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_dout = '{16'h00A5, 16'h0001, 16'h0002, 16'h0003, 16'h0004};

        rst        = 1'b1;
        wr_data    = '0;
        wr_valid   = '0;
        rd_valid   = 1'b0;
        dout_ready = 1'b0;

        // Reset held for two edges.
        @(negedge clk);
        checkOutput("reset_wr_ready_during", 32'(wr_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < NW; i++) setData(i, W'(i + 1));
        wr_valid = 4'b1111;
        @(negedge clk);
        checkOutput("reset_dout_data", 32'(dout_data), 32'h00A5);
        checkOutput("reset_upd_cnt",   32'(upd_cnt),   32'd0);

        // Round-robin with every requester active.
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            checkOutput("rr_grant", 32'(wr_ready),  32'(rr_gnt[i]));
            checkOutput("rr_dout",  32'(dout_data), 32'(rr_dout[i]));
        end
        applyStimulus(4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("rr_dout_last",  32'(dout_data), 32'h0001);
        checkOutput("rr_upd_cnt",    32'(upd_cnt),   32'd5);
        checkOutput("rr_grant_idx",  32'(grant_idx), 32'd0);

        // Stall: pending write from requester 1 while the read response is blocked.
        setData(1, 16'h0BEE);
        applyStimulus(4'b0010, 1'b1, 1'b0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("stall_wr_ready", 32'(wr_ready),  32'd0);
            checkOutput("stall_dout",     32'(dout_data), 32'h0001);
        end
        applyStimulus(4'b0010, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("stall_release_grant", 32'(wr_ready), 32'b0010);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("stall_write_landed", 32'(dout_data), 32'h0BEE);
        checkOutput("stall_upd_cnt",      32'(upd_cnt),   32'd6);

        // Same-cycle read and write from requester 2.
        setData(2, 16'h0010);
        applyStimulus(4'b0100, 1'b0, 1'b0);
        #0;
        @(posedge clk);
        #1;
        setData(2, 16'h0020);
        rd_valid   = 1'b1;
        dout_ready = 1'b1;
        @(negedge clk);
        checkOutput("rw_grant", 32'(wr_ready), 32'b0100);
`ifdef STATE_ARBITER_FWD_EN
        checkOutput("rw_dout_fwd", 32'(dout_data), 32'h0020);
`else
        checkOutput("rw_dout_old", 32'(dout_data), 32'h0010);
`endif
        applyStimulus(4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("rw_state_after", 32'(dout_data), 32'h0020);
        checkOutput("rw_upd_cnt",     32'(upd_cnt),   32'd8);

        // Reset while stalled with every writer pending.
        applyStimulus(4'b1111, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_wr_ready", 32'(wr_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_dout",      32'(dout_data), 32'h00A5);
        checkOutput("midrst_upd_cnt",   32'(upd_cnt),   32'd0);
        checkOutput("midrst_grant_idx", 32'(grant_idx), 32'd0);
        checkOutput("midrst_wr_ready2", 32'(wr_ready),  32'd0);
        applyStimulus(4'b1111, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("midrst_ptr_zero", 32'(wr_ready), 32'b0001);

        // 256 accepted writes bring the counter back to zero.
        repeat (256) @(posedge clk);
        #1;
        wr_valid = '0;
        rd_valid = 1'b0;
        @(negedge clk);
        checkOutput("wrap_upd_cnt",   32'(upd_cnt),   32'd0);
        checkOutput("wrap_grant_idx", 32'(grant_idx), 32'd3);
        checkOutput("wrap_dout",      32'(dout_data), 32'h0004);

        @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
